// File: rtl/divider_seq.sv
// -----------------------------------------------------------------------------
// divider_seq
//
// Sequential unsigned divider for the sonar sample chain. It undoes the
// constant-gain multiplier stage by dividing an amplified sample by an
// attenuation factor. A restoring shift-subtract loop produces one quotient
// bit per clock. A start/ready/valid handshake lets the block sit between
// pipelined DSP stages.
//
// Parameters:
//   n   operand and result width in bits (n >= 2)
//   CW  width of the internal bit counter
//
// Ports:
//   clk          system clock, rising-edge active
//   rst          asynchronous, active-high reset
//   start_i      request pulse; accepted only while ready_o = 1
//   data_i       dividend, sampled on the accepting edge
//   attenuate_i  divisor, sampled on the accepting edge
//   ready_o      high while idle and able to accept start_i
//   valid_o      one-cycle pulse; results valid now and held afterwards
//   div_zero_o   set with valid_o when the divisor was 0; held with results
//   quotient_o   quotient (all ones on divide by zero)
//   remainder_o  remainder (the dividend on divide by zero)
// -----------------------------------------------------------------------------
module divider_seq #(
    parameter int n  = 32,
    parameter int CW = $clog2(n + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [n-1:0] data_i,
    input  logic [n-1:0] attenuate_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic         div_zero_o,
    output logic [n-1:0] quotient_o,
    output logic [n-1:0] remainder_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Working registers. The partial remainder is always below the divisor,
    // so n bits hold it; only the shifted trial value needs the extra bit.
    logic [n-1:0]  rem;
    logic [n-1:0]  dq;        // dividend shifting out, quotient shifting in
    logic [n-1:0]  divisor;
    logic [CW-1:0] count;

    logic          accept;
    logic          last_step;
    logic [n:0]    shifted;
    logic          fits;
    logic [n-1:0]  diff;
    logic [n-1:0]  rem_next;
    logic [n-1:0]  dq_next;

    assign accept    = (state == IDLE) && start_i;
    assign last_step = (state == CALC) && (count == CW'(1));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches on paths that do not change state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = (attenuate_i == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state)
            IDLE:    ready_o = 1'b1;
            DONE:    valid_o = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // One restoring step: shift {rem, dq} left, try to subtract the divisor.
    // When the trial fits, the true difference is below the divisor and thus
    // fits in n bits, so an n-bit subtraction of the low bits is exact.
    // -------------------------------------------------------------------------
    always_comb begin
        shifted  = {rem, dq[n-1]};
        fits     = (shifted >= {1'b0, divisor});
        diff     = shifted[n-1:0] - divisor;
        rem_next = fits ? diff : shifted[n-1:0];
        dq_next  = {dq[n-2:0], fits};
    end

    // -------------------------------------------------------------------------
    // Datapath and result registers. Results change only on the edge that
    // enters DONE: the accepting edge for a zero divisor, the last CALC step
    // otherwise.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem         <= '0;
            dq          <= '0;
            divisor     <= '0;
            count       <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div_zero_o  <= 1'b0;
        end else if (accept) begin
            rem     <= '0;
            dq      <= data_i;
            divisor <= attenuate_i;
            count   <= CW'(n);
            if (attenuate_i == '0) begin
                quotient_o  <= '1;
                remainder_o <= data_i;
                div_zero_o  <= 1'b1;
            end
        end else if (state == CALC) begin
            rem   <= rem_next;
            dq    <= dq_next;
            count <= count - CW'(1);
            if (last_step) begin
                quotient_o  <= dq_next;
                remainder_o <= rem_next;
                div_zero_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// -----------------------------------------------------------------------------
// tb_divider_seq
//
// Self-checking bench for divider_seq (n = 32). Directed vectors come from a
// table of known quotients and remainders. Hand-written sequences cover the
// ignored second request and the reset abort. Random operands are checked
// against plain integer division.
// -----------------------------------------------------------------------------
module tb_divider_seq;

    localparam int N  = 32;
    localparam int CW = $clog2(N + 1);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [N-1:0] data_i = '0;
    logic [N-1:0] attenuate_i = '0;
    logic         ready_o;
    logic         valid_o;
    logic         div_zero_o;
    logic [N-1:0] quotient_o;
    logic [N-1:0] remainder_o;

    divider_seq #(.n(N), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .data_i      (data_i),
        .attenuate_i (attenuate_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .div_zero_o  (div_zero_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] q, output logic [N-1:0] r,
                         output logic dz, output int lat);
        if (b == '0) begin
            q = '1; r = a; dz = 1'b1; lat = 1;
        end else begin
            q = a / b; r = a % b; dz = 1'b0; lat = N + 1;
        end
    endtask

    // Issue one request from IDLE and wait (bounded) for valid_o. Edges are
    // counted with the accepting edge as edge 1. Returns at the negedge where
    // valid_o is seen.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output int edges, output bit ready_low_ok, output bit got_valid);
        @(negedge clk);
        start_i     = 1'b1;
        data_i      = a;
        attenuate_i = b;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start_i      = 1'b0;
        data_i       = $urandom;   // operand changes after acceptance must not matter
        attenuate_i  = $urandom;
        ready_low_ok = 1'b1;
        while (!valid_o && edges < 100) begin
            if (ready_o) ready_low_ok = 1'b0;
            @(negedge clk);
            edges++;
        end
        got_valid = valid_o;
        if (ready_o) ready_low_ok = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] q_exp, input logic [N-1:0] r_exp,
                         input logic dz_exp, input bit full);
        int  edges;
        int  lat_exp;
        bit  rdy_ok;
        bit  got;
        logic [N-1:0] q_m, r_m;
        logic dz_m;
        model(a, b, q_m, r_m, dz_m, lat_exp);
        run_op(a, b, edges, rdy_ok, got);
        check({name, " valid_seen"}, got, 1'b1);
        check({name, " latency"}, edges, lat_exp);
        check({name, " quotient"}, quotient_o, q_exp);
        check({name, " remainder"}, remainder_o, r_exp);
        check({name, " div_zero"}, div_zero_o, dz_exp);
        if (full) begin
            check({name, " ready_low"}, rdy_ok, 1'b1);
            @(negedge clk);
            check({name, " valid_pulse"}, valid_o, 1'b0);
            check({name, " hold_q"}, quotient_o, q_exp);
            check({name, " ready_again"}, ready_o, 1'b1);
        end
    endtask

    typedef struct {
        string        name;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int           nvalid;
        int           vk;
        logic [N-1:0] qv, rv;
        logic [N-1:0] ra, rb, rq, rr;
        logic         rdz;
        int           rlat;

        vecs[0] = '{"1000/7",   32'd1000,     32'd7,         32'd142,      32'd6, 1'b0};
        vecs[1] = '{"max/1",    32'hFFFFFFFF, 32'd1,         32'hFFFFFFFF, 32'd0, 1'b0};
        vecs[2] = '{"max/max",  32'hFFFFFFFF, 32'hFFFFFFFF,  32'd1,        32'd0, 1'b0};
        vecs[3] = '{"3/10",     32'd3,        32'd10,        32'd0,        32'd3, 1'b0};
        vecs[4] = '{"0/5",      32'd0,        32'd5,         32'd0,        32'd0, 1'b0};
        vecs[5] = '{"5/0",      32'd5,        32'd0,         32'hFFFFFFFF, 32'd5, 1'b1};
        vecs[6] = '{"9/2",      32'd9,        32'd2,         32'd4,        32'd1, 1'b0};
        vecs[7] = '{"0/0",      32'd0,        32'd0,         32'hFFFFFFFF, 32'd0, 1'b1};

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset ready", ready_o, 1'b1);
        check("reset valid", valid_o, 1'b0);
        check("reset div_zero", div_zero_o, 1'b0);
        check("reset quotient", quotient_o, '0);
        check("reset remainder", remainder_o, '0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, 1'b1);
        end

        // Second request during CALC is ignored; exactly one valid_o
        @(negedge clk);
        start_i = 1'b1; data_i = 32'd100; attenuate_i = 32'd3;
        nvalid = 0; vk = 0; qv = '0; rv = '0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (k == 1)  start_i = 1'b0;
            if (k == 10) begin start_i = 1'b1; data_i = 32'd50; attenuate_i = 32'd5; end
            if (k == 11) start_i = 1'b0;
            if (valid_o) begin
                nvalid++;
                vk = k;
                qv = quotient_o;
                rv = remainder_o;
            end
        end
        check("ignore valid_count", nvalid, 1);
        check("ignore latency", vk, N + 1);
        check("ignore quotient", qv, 32'd33);
        check("ignore remainder", rv, 32'd1);

        // Reset mid-CALC: asynchronous clear, no valid, ready after release
        @(negedge clk);
        start_i = 1'b1; data_i = 32'd1000; attenuate_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (14) @(negedge clk);
        check("abort busy", ready_o, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("abort ready", ready_o, 1'b1);
        check("abort valid", valid_o, 1'b0);
        check("abort quotient", quotient_o, '0);
        check("abort remainder", remainder_o, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nvalid = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_o) nvalid++;
        end
        check("abort no_valid", nvalid, 0);
        check("abort ready_idle", ready_o, 1'b1);
        do_op("after_abort 20/6", 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 1'b1);

        // Random operands against integer division
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = $urandom_range(0, 255);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       rb = $urandom_range(0, 15);
                1:       rb = $urandom >> $urandom_range(0, 31);
                2:       rb = ra + $urandom_range(0, 3);
                default: rb = $urandom;
            endcase
            model(ra, rb, rq, rr, rdz, rlat);
            do_op($sformatf("rand%0d %0h/%0h", i, ra, rb), ra, rb, rq, rr, rdz, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
